// File: rtl/imm_pkg.sv
// Shared immediate-type encodings, field bit positions and encoder state encoding.
// Latency: none (package).
// Backpressure: not applicable.
package imm_pkg;

    // in_ctrl encodings (also used by the sign extender)
    localparam logic [2:0] IMM_I    = 3'b000;
    localparam logic [2:0] IMM_D    = 3'b001;
    localparam logic [2:0] IMM_B    = 3'b010;
    localparam logic [2:0] IMM_CB   = 3'b011;
    localparam logic [2:0] IMM_MOVZ = 3'b100;

    // LSB positions of each immediate inside the 26-bit field
    localparam int I_IMM_LSB   = 10;  // field[21:10], 12 bits, zero-extended
    localparam int D_IMM_LSB   = 12;  // field[20:12], 9 bits, sign-extended
    localparam int B_IMM_LSB   = 0;   // field[25:0], 26 bits, sign-extended
    localparam int CB_IMM_LSB  = 5;   // field[23:5], 19 bits, sign-extended
    localparam int MOV_IMM_LSB = 5;   // field[20:5], 16-bit halfword
    localparam int MOV_HW_LSB  = 21;  // field[22:21], halfword index

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EMIT   = 2'd1,
        ST_MOVSEQ = 2'd2
    } enc_state_e;

endpackage

// File: rtl/movz_hw_picker.sv
// Picks the lowest pending halfword of a MOVZ/MOVK sequence and the mask left after it.
// Latency: combinational.
// Backpressure: none; pure function of the mask.
module movz_hw_picker (
    input  logic [3:0] mask,
    output logic [1:0] hw,
    output logic [3:0] rest,
    output logic       last
);

    // lowest set bit wins; an empty mask maps to hw 0 (the value==0 single MOVZ)
    always_comb begin
        hw = 2'd0;
        if (mask[0])      hw = 2'd0;
        else if (mask[1]) hw = 2'd1;
        else if (mask[2]) hw = 2'd2;
        else if (mask[3]) hw = 2'd3;
        rest = mask & (mask - 4'd1);
        last = (rest == 4'd0);
    end

endmodule

// File: rtl/imm_field_encoder.sv
// Encodes a 64-bit constant into 26-bit instruction immediate field beats (I/D/B/CB single, MOVZ+MOVK multi).
// Latency: first beat registered, out_valid one cycle after accept; later MOVK beats one per retire.
// Backpressure: beat held stable while out_ready low; in_ready only in IDLE, so at most 1 request per 2 cycles.
module imm_field_encoder
    import imm_pkg::*;
(
    input  logic        CLK,
    input  logic        resetl,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_value,
    input  logic [2:0]  in_ctrl,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [25:0] out_field,
    output logic        out_movk,
    output logic        out_last,
    output logic        out_err
);

    enc_state_e  state_q, state_d;
    logic [63:0] val_q;
    logic [3:0]  mask_q;   // halfwords still to be emitted after the current beat

    logic        accept, retire;
    logic [3:0]  in_mask, pick_mask, pick_rest;
    logic [63:0] pick_val;
    logic [1:0]  pick_hw;
    logic        pick_last;
    logic [15:0] pick_hword;
    logic [25:0] mov_field;
    logic [25:0] sb_field;
    logic        sb_err;

    assign in_ready = (state_q == ST_IDLE);
    assign accept   = in_valid && in_ready;
    assign retire   = out_valid && out_ready;

    // nonzero-halfword mask of the incoming constant; picker sees it on accept, the latched rest afterwards
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            in_mask[i] = (in_value[16*i +: 16] != 16'd0);
        end
        pick_mask  = (state_q == ST_IDLE) ? in_mask  : mask_q;
        pick_val   = (state_q == ST_IDLE) ? in_value : val_q;
        pick_hword = pick_val[16*pick_hw +: 16];
        mov_field  = (26'(pick_hw) << MOV_HW_LSB) | (26'(pick_hword) << MOV_IMM_LSB);
    end

    movz_hw_picker u_picker (
        .mask (pick_mask),
        .hw   (pick_hw),
        .rest (pick_rest),
        .last (pick_last)
    );

    // single-beat encoding with range check; out-of-range or illegal ctrl yields err with a zero field
    always_comb begin
        sb_field = 26'd0;
        sb_err   = 1'b0;
        case (in_ctrl)
            IMM_I: begin
                if (in_value[63:12] == 52'd0) sb_field = 26'(in_value[11:0]) << I_IMM_LSB;
                else                          sb_err   = 1'b1;
            end
            IMM_D: begin
                if ((&in_value[63:8]) || !(|in_value[63:8])) sb_field = 26'(in_value[8:0]) << D_IMM_LSB;
                else                                         sb_err   = 1'b1;
            end
            IMM_B: begin
                if ((&in_value[63:25]) || !(|in_value[63:25])) sb_field = in_value[25:0] << B_IMM_LSB;
                else                                           sb_err   = 1'b1;
            end
            IMM_CB: begin
                if ((&in_value[63:18]) || !(|in_value[63:18])) sb_field = 26'(in_value[18:0]) << CB_IMM_LSB;
                else                                           sb_err   = 1'b1;
            end
            default: sb_err = 1'b1;
        endcase
    end

    // state register
    always_ff @(posedge CLK) begin
        if (!resetl) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept) state_d = (in_ctrl == IMM_MOVZ) ? ST_MOVSEQ : ST_EMIT;
            ST_EMIT:   if (retire) state_d = ST_IDLE;
            ST_MOVSEQ: if (retire && out_last) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // output beat registers and MOV sequence context; cleared when the request finishes
    always_ff @(posedge CLK) begin
        if (!resetl) begin
            out_valid <= 1'b0;
            out_field <= 26'd0;
            out_movk  <= 1'b0;
            out_last  <= 1'b0;
            out_err   <= 1'b0;
            val_q     <= 64'd0;
            mask_q    <= 4'd0;
        end else if (accept) begin
            out_valid <= 1'b1;
            if (in_ctrl == IMM_MOVZ) begin
                out_field <= mov_field;
                out_movk  <= 1'b0;
                out_last  <= pick_last;
                out_err   <= 1'b0;
                val_q     <= in_value;
                mask_q    <= pick_rest;
            end else begin
                out_field <= sb_field;
                out_movk  <= 1'b0;
                out_last  <= 1'b1;
                out_err   <= sb_err;
            end
        end else if (retire) begin
            if (state_q == ST_MOVSEQ && !out_last) begin
                out_field <= mov_field;
                out_movk  <= 1'b1;
                out_last  <= pick_last;
                mask_q    <= pick_rest;
            end else begin
                out_valid <= 1'b0;
                out_field <= 26'd0;
                out_movk  <= 1'b0;
                out_last  <= 1'b0;
                out_err   <= 1'b0;
                mask_q    <= 4'd0;
            end
        end
    end

endmodule

// File: tb/tb_imm_field_encoder.sv
module tb_imm_field_encoder;

    logic        CLK = 1'b0;
    logic        resetl;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_value;
    logic [2:0]  in_ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [25:0] out_field;
    logic        out_movk;
    logic        out_last;
    logic        out_err;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 CLK = ~CLK;

    imm_field_encoder dut (
        .CLK       (CLK),
        .resetl    (resetl),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_value  (in_value),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_field (out_field),
        .out_movk  (out_movk),
        .out_last  (out_last),
        .out_err   (out_err)
    );

    typedef struct {
        logic [63:0] value;
        logic [2:0]  ctrl;
        logic [25:0] field;
        logic        err;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // present a request at a negedge, return at the negedge after the accepting posedge
    task automatic issue(input logic [63:0] v, input logic [2:0] c);
        int t = 0;
        @(negedge CLK);
        while (!in_ready && t < 20) begin
            @(negedge CLK);
            t++;
        end
        if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_value = v;
        in_ctrl  = c;
        @(posedge CLK);
        @(negedge CLK);
        in_valid = 1'b0;
    endtask

    // capture the beat visible at this negedge and retire it
    task automatic take(output logic [25:0] f, output logic mk, output logic ls, output logic er);
        int t = 0;
        out_ready = 1'b1;
        while (!out_valid && t < 20) begin
            @(negedge CLK);
            t++;
        end
        if (!out_valid) check("out_valid_timeout", 64'(out_valid), 64'd1);
        f  = out_field;
        mk = out_movk;
        ls = out_last;
        er = out_err;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    function automatic logic [63:0] decode(input logic [2:0] c, input logic [25:0] f);
        case (c)
            3'b000:  decode = {52'd0, f[21:10]};
            3'b001:  decode = {{55{f[20]}}, f[20:12]};
            3'b010:  decode = {{38{f[25]}}, f[25:0]};
            3'b011:  decode = {{45{f[23]}}, f[23:5]};
            default: decode = 64'd0;
        endcase
    endfunction

    vec_t vecs[15];

    initial begin
        logic [25:0] f;
        logic        mk, ls, er;
        logic [63:0] v, acc;
        logic [31:0] r0, r1;
        int          nb;

        vecs[0]  = '{64'h123,                3'd0, 26'h0048C00, 1'b0};
        vecs[1]  = '{64'hFFFFFFFFFFFFFFFC,   3'd1, 26'h01FC000, 1'b0};
        vecs[2]  = '{64'h40000,              3'd3, 26'h0,       1'b1};
        vecs[3]  = '{64'h1000,               3'd0, 26'h0,       1'b1};
        vecs[4]  = '{64'hFFF,                3'd0, 26'h03FFC00, 1'b0};
        vecs[5]  = '{64'hFF,                 3'd1, 26'h00FF000, 1'b0};
        vecs[6]  = '{64'h100,                3'd1, 26'h0,       1'b1};
        vecs[7]  = '{64'hFFFFFFFFFFFFFF00,   3'd1, 26'h0100000, 1'b0};
        vecs[8]  = '{64'h1FFFFFF,            3'd2, 26'h1FFFFFF, 1'b0};
        vecs[9]  = '{64'h2000000,            3'd2, 26'h0,       1'b1};
        vecs[10] = '{64'hFFFFFFFFFE000000,   3'd2, 26'h2000000, 1'b0};
        vecs[11] = '{64'h3FFFF,              3'd3, 26'h07FFFE0, 1'b0};
        vecs[12] = '{64'hFFFFFFFFFFFFFFFF,   3'd3, 26'h0FFFFE0, 1'b0};
        vecs[13] = '{64'h5,                  3'd5, 26'h0,       1'b1};
        vecs[14] = '{64'h0,                  3'd7, 26'h0,       1'b1};

        resetl    = 1'b0;
        in_valid  = 1'b0;
        in_value  = 64'd0;
        in_ctrl   = 3'd0;
        out_ready = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        resetl = 1'b1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_field", 64'(out_field), 64'd0);
        check("rst_out_flags", {61'd0, out_movk, out_last, out_err}, 64'd0);
        check("rst_in_ready",  64'(in_ready), 64'd1);

        // single-beat table
        for (int i = 0; i < 15; i++) begin
            issue(vecs[i].value, vecs[i].ctrl);
            check("lat1_out_valid", 64'(out_valid), 64'd1);
            check("busy_in_ready",  64'(in_ready), 64'd0);
            take(f, mk, ls, er);
            check("sb_field", 64'(f), 64'(vecs[i].field));
            check("sb_err",   64'(er), 64'(vecs[i].err));
            check("sb_last",  64'(ls), 64'd1);
            check("sb_movk",  64'(mk), 64'd0);
            check("sb_idle_valid", 64'(out_valid), 64'd0);
        end

        // MOVZ two beats with backpressure on beat1
        out_ready = 1'b0;
        issue(64'h000012340000ABCD, 3'd4);
        for (int k = 0; k < 3; k++) begin
            check("bp_valid",    64'(out_valid), 64'd1);
            check("bp_field",    64'(out_field), 64'h01579A0);
            check("bp_flags",    {61'd0, out_movk, out_last, out_err}, 64'd0);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            @(negedge CLK);
        end
        take(f, mk, ls, er);
        check("mz_b1_field", 64'(f), 64'h01579A0);
        check("mz_b1_flags", {61'd0, mk, ls, er}, 64'd0);
        take(f, mk, ls, er);
        check("mz_b2_field", 64'(f), 64'h0424680);
        check("mz_b2_flags", {61'd0, mk, ls, er}, 64'b110);
        check("mz_done_valid", 64'(out_valid), 64'd0);

        // MOVZ of zero
        issue(64'd0, 3'd4);
        take(f, mk, ls, er);
        check("mz0_field", 64'(f), 64'd0);
        check("mz0_flags", {61'd0, mk, ls, er}, 64'b010);
        check("mz0_done_valid", 64'(out_valid), 64'd0);

        // reset mid-sequence
        issue(64'hFFFFFFFFFFFFFFFF, 3'd4);
        take(f, mk, ls, er);
        check("mzr_b1_field", 64'(f), 64'h01FFFE0);
        check("mzr_b1_last",  64'(ls), 64'd0);
        out_ready = 1'b0;
        check("mzr_b2_field", 64'(out_field), 64'h03FFFE0);
        resetl = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        check("mzr_valid", 64'(out_valid), 64'd0);
        check("mzr_field", 64'(out_field), 64'd0);
        check("mzr_flags", {61'd0, out_movk, out_last, out_err}, 64'd0);
        resetl = 1'b1;
        @(negedge CLK);
        check("mzr_in_ready", 64'(in_ready), 64'd1);
        check("mzr_still_idle", 64'(out_valid), 64'd0);
        out_ready = 1'b1;

        // random round-trip, 1000 legal values per type
        for (int c = 0; c < 5; c++) begin
            for (int n = 0; n < 1000; n++) begin
                r0 = $urandom;
                r1 = $urandom;
                case (c)
                    0: v = {52'd0, r0[11:0]};
                    1: v = {{55{r0[8]}}, r0[8:0]};
                    2: v = {{38{r0[25]}}, r0[25:0]};
                    3: v = {{45{r0[18]}}, r0[18:0]};
                    default: begin
                        v = {r1, r0};
                        for (int h = 0; h < 4; h++) if ($urandom_range(0, 2) == 0) v[16*h +: 16] = 16'd0;
                    end
                endcase
                issue(v, 3'(c));
                if (c < 4) begin
                    take(f, mk, ls, er);
                    check("rt_sb_value", decode(3'(c), f), v);
                    check("rt_sb_flags", {61'd0, mk, ls, er}, 64'b010);
                end else begin
                    acc = 64'd0;
                    nb  = 0;
                    ls  = 1'b0;
                    while (!ls && nb < 5) begin
                        take(f, mk, ls, er);
                        if (nb == 0) acc = 64'd0;
                        acc[16*f[22:21] +: 16] = f[20:5];
                        check("rt_mv_movk", 64'(mk), (nb == 0) ? 64'd0 : 64'd1);
                        check("rt_mv_err",  64'(er), 64'd0);
                        nb++;
                    end
                    check("rt_mv_value", acc, v);
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
